// File: rtl/fpga_ser_pkg.sv
// Shared types and helpers for the fabric serializer: word container and bit reversal.
package fpga_ser_pkg;

   localparam int MAX_WIDTH = 32;

   typedef logic [MAX_WIDTH-1:0] ser_word_t;

   function automatic ser_word_t bit_rev(input ser_word_t w);
      ser_word_t r;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         r[i] = w[MAX_WIDTH-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fpga_ser_lane.sv
// One serializer lane: shift register plus registered serial output q.
module fpga_ser_lane
   import fpga_ser_pkg::*;
#(
   parameter int WIDTH     = 10,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             load,
   input  logic [WIDTH-1:0] ld_word,
   output logic             q
);

   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] send_word;
   logic [WIDTH-1:0] nxt;

   // Reversing MSB-first words on load is equivalent to shifting them left, so
   // both modes share a right shift and always transmit bit 0.
   always_comb begin
      send_word = MSB_FIRST ? WIDTH'(bit_rev(ser_word_t'(ld_word)) >> (MAX_WIDTH - WIDTH))
                            : ld_word;
      nxt       = load ? send_word : (shreg >> 1);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         shreg <= '0;
         q     <= 1'b0;
      end else begin
         shreg <= nxt;
         q     <= nxt[0];
      end
   end

endmodule

// File: rtl/fpga_soft_serdes_tx.sv
// N-lane WIDTH:1 fabric serializer with valid/ready input, 1-deep skid buffer and idle insertion.
module fpga_soft_serdes_tx
   import fpga_ser_pkg::*;
#(
   parameter int              NCH       = 1,
   parameter int              WIDTH     = 10,
   parameter bit              MSB_FIRST = 1'b0,
   parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NCH*WIDTH-1:0] in_data,
   output logic [NCH-1:0]       q,
   output logic                 word_start,
   output logic                 underrun,
   input  logic                 clr_underrun
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0]     cnt;
   logic [NCH*WIDTH-1:0] buf_word;
   logic                 buf_full;
   logic                 started;
   logic                 load;
   logic                 accept;

   assign load     = (cnt == CNT_LAST);
   assign in_ready = !buf_full || load;
   assign accept   = in_valid && in_ready;

   // started masks the underrun that would otherwise fire on the first load after reset.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         cnt        <= CNT_LAST;
         buf_word   <= '0;
         buf_full   <= 1'b0;
         started    <= 1'b0;
         word_start <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         cnt        <= load ? '0 : cnt + CNT_W'(1);
         word_start <= load;
         if (load) begin
            started <= 1'b1;
         end
         if (accept) begin
            buf_word <= in_data;
            buf_full <= 1'b1;
         end else if (load) begin
            buf_full <= 1'b0;
         end
         if (load && !buf_full && started) begin
            underrun <= 1'b1;
         end else if (clr_underrun) begin
            underrun <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_lane
      fpga_ser_lane #(
         .WIDTH     (WIDTH),
         .MSB_FIRST (MSB_FIRST)
      ) u_lane (
         .clk     (clk),
         .arst    (arst),
         .load    (load),
         .ld_word (buf_full ? buf_word[k*WIDTH +: WIDTH] : IDLE_WORD),
         .q       (q[k])
      );
   end

endmodule

// File: tb/tb_fpga_soft_serdes_tx.sv
// Randomized bench: a 3-lane LSB-first and a 1-lane MSB-first serializer share one stimulus
// stream and are checked against a word-queue reference model.
module tb_fpga_soft_serdes_tx;

   localparam int         W    = 10;
   localparam int         NCH  = 3;
   localparam logic [9:0] IDLE = 10'h354;

   logic          clk = 1'b0;
   logic          arst;
   logic          in_valid;
   logic          in_ready;
   logic          in_ready_m;
   logic [29:0]   in_data;
   logic [2:0]    q;
   logic          q_m;
   logic          word_start;
   logic          word_start_m;
   logic          underrun;
   logic          underrun_m;
   logic          clr_underrun;

   // Reference model: queue of accepted words, word on the wire, slot counter since reset.
   int            k;
   logic [29:0]   mq[$];
   logic [29:0]   cur;
   logic          expU;
   logic [2:0]    logLsb[64];
   logic          logMsb[64];

   int            nCompared   = 0;
   int            nMismatched = 0;

   always #5 clk = ~clk;

   fpga_soft_serdes_tx #(
      .NCH       (NCH),
      .WIDTH     (W),
      .MSB_FIRST (1'b0),
      .IDLE_WORD (IDLE)
   ) dut (
      .clk          (clk),
      .arst         (arst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .q            (q),
      .word_start   (word_start),
      .underrun     (underrun),
      .clr_underrun (clr_underrun)
   );

   fpga_soft_serdes_tx #(
      .NCH       (1),
      .WIDTH     (W),
      .MSB_FIRST (1'b1),
      .IDLE_WORD (IDLE)
   ) dutMsb (
      .clk          (clk),
      .arst         (arst),
      .in_valid     (in_valid),
      .in_ready     (in_ready_m),
      .in_data      (in_data[9:0]),
      .q            (q_m),
      .word_start   (word_start_m),
      .underrun     (underrun_m),
      .clr_underrun (clr_underrun)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
      nCompared++;
      if (obs !== expVal) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expVal);
      end
   endtask

   // One serial clock: drive inputs, advance the model at the edge, check outputs on the negedge.
   task automatic applyStimulus(input logic v, input logic [29:0] d, input logic c,
                                output logic accepted);
      logic       isLoad;
      logic       expReady;
      logic       hadBuf;
      int         bitIdx;
      logic [2:0] expQ;
      in_valid     = v;
      in_data      = d;
      clr_underrun = c;
      isLoad   = ((k % W) == 0);
      expReady = (mq.size() == 0) || isLoad;
      checkOutput("in_ready", 32'(in_ready), 32'(expReady));
      checkOutput("in_ready_msb", 32'(in_ready_m), 32'(expReady));
      accepted = v && expReady;
      @(posedge clk);
      hadBuf = (mq.size() > 0);
      if (isLoad) begin
         if (hadBuf) cur = mq.pop_front();
         else        cur = {3{IDLE}};
      end
      if (isLoad && !hadBuf && k > 0) expU = 1'b1;
      else if (c)                     expU = 1'b0;
      if (accepted) mq.push_back(d);
      bitIdx = k % W;
      for (int l = 0; l < NCH; l++) begin
         expQ[l] = cur[l*W + bitIdx];
      end
      @(negedge clk);
      checkOutput("q", 32'(q), 32'(expQ));
      checkOutput("q_msb", 32'(q_m), 32'(cur[W-1-bitIdx]));
      checkOutput("word_start", 32'(word_start), 32'(isLoad));
      checkOutput("word_start_msb", 32'(word_start_m), 32'(isLoad));
      checkOutput("underrun", 32'(underrun), 32'(expU));
      checkOutput("underrun_msb", 32'(underrun_m), 32'(expU));
      if (k < 64) begin
         logLsb[k] = q;
         logMsb[k] = q_m;
      end
      k++;
   endtask

   initial begin
      logic        acc;
      logic        done;
      logic        haveWord;
      logic [29:0] w;
      logic [9:0]  seqA;
      logic [9:0]  seqM;
      logic [9:0]  lane0;
      logic [9:0]  lane1;
      logic [9:0]  lane2;
      logic [9:0]  idleSeq;

      arst = 1'b1; in_valid = 1'b0; in_data = '0; clr_underrun = 1'b0;
      k = 0; expU = 1'b0; cur = '0; acc = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_q", 32'(q), 32'h0);
      checkOutput("reset_q_msb", 32'(q_m), 32'h0);
      checkOutput("reset_word_start", 32'(word_start), 32'h0);
      checkOutput("reset_underrun", 32'(underrun), 32'h0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'h1);
      arst = 1'b0;

      // Directed: word A then word B, then starve so idle words and underrun appear.
      applyStimulus(1'b1, {10'h3FF, 10'h200, 10'h2A5}, 1'b0, acc);
      checkOutput("accept_A", 32'(acc), 32'h1);
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         applyStimulus(1'b1, {10'h3FF, 10'h200, 10'h001}, 1'b0, acc);
         done = acc;
      end
      checkOutput("accept_B", 32'(done), 32'h1);
      while (k < 40) applyStimulus(1'b0, 30'($urandom), 1'b0, acc);
      applyStimulus(1'b0, 30'($urandom), 1'b1, acc);
      checkOutput("underrun_hold", 32'(underrun), 32'h1);
      while (k < 45) applyStimulus(1'b0, 30'($urandom), 1'b0, acc);
      applyStimulus(1'b0, 30'($urandom), 1'b1, acc);
      checkOutput("underrun_clr", 32'(underrun), 32'h0);

      for (int i = 0; i < W; i++) begin
         seqA[i]    = logLsb[10+i][0];
         seqM[W-1-i] = logMsb[10+i];
         lane0[i]   = logLsb[20+i][0];
         lane1[i]   = logLsb[20+i][1];
         lane2[i]   = logLsb[20+i][2];
         idleSeq[i] = logLsb[30+i][0];
      end
      checkOutput("lsb_word_2A5", 32'(seqA), 32'h2A5);
      checkOutput("msb_word_2A5", 32'(seqM), 32'h2A5);
      checkOutput("lane0_001", 32'(lane0), 32'h001);
      checkOutput("lane1_200", 32'(lane1), 32'h200);
      checkOutput("lane2_3FF", 32'(lane2), 32'h3FF);
      checkOutput("idle_word", 32'(idleSeq), 32'h354);

      // Back-to-back stream 0..7 with valid held high.
      for (int i = 0; i < 8; i++) begin
         done = 1'b0;
         for (int t = 0; t < 20 && !done; t++) begin
            applyStimulus(1'b1, {3{10'(i)}}, 1'b0, acc);
            done = acc;
         end
         checkOutput("stream_accept", 32'(done), 32'h1);
      end
      checkOutput("underrun_stream", 32'(underrun), 32'h0);

      // Random traffic: dense first, sparse later so starvation occurs.
      haveWord = 1'b0;
      w = '0;
      for (int i = 0; i < 400; i++) begin
         if (!haveWord && ($urandom_range(0, 9) < ((i < 200) ? 8 : 1))) begin
            haveWord = 1'b1;
            w = 30'($urandom);
         end
         applyStimulus(haveWord, haveWord ? w : 30'($urandom), ($urandom_range(0, 15) == 0), acc);
         if (acc) haveWord = 1'b0;
      end

      // Mid-word reset while bit 4 is on q and the buffer holds a word.
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         if (!haveWord) begin
            haveWord = 1'b1;
            w = 30'($urandom);
         end
         applyStimulus(1'b1, w, 1'b0, acc);
         if (acc) haveWord = 1'b0;
         done = ((k % W) == 5) && (mq.size() > 0);
      end
      checkOutput("reset_setup", 32'(done), 32'h1);
      arst = 1'b1;
      #1;
      checkOutput("midrst_q", 32'(q), 32'h0);
      checkOutput("midrst_q_msb", 32'(q_m), 32'h0);
      checkOutput("midrst_in_ready", 32'(in_ready), 32'h1);
      checkOutput("midrst_underrun", 32'(underrun), 32'h0);
      checkOutput("midrst_word_start", 32'(word_start), 32'h0);
      @(negedge clk);
      arst = 1'b0;
      k = 0; mq.delete(); expU = 1'b0; cur = '0;
      haveWord = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (!haveWord && ($urandom_range(0, 3) == 0)) begin
            haveWord = 1'b1;
            w = 30'($urandom);
         end
         applyStimulus(haveWord, haveWord ? w : 30'($urandom), 1'b0, acc);
         if (acc) haveWord = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
